// File: rtl/vga_pkg.sv
// Shared text-mode constants and arbiter state encoding for the VGA text path.
package vga_pkg;
  localparam int          TEXT_COLS  = 80;
  localparam int          TEXT_ROWS  = 25;
  localparam int          CELLS      = TEXT_COLS * TEXT_ROWS;
  localparam logic [15:0] BLANK_CELL = 16'h0720;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    CAPTURE = 3'd2,
    ACK     = 3'd3,
    CLEAR   = 3'd4
  } arb_state_e;
endpackage

// File: rtl/vram_bram.sv
// 2048x16 single-port text RAM, byte-writable, registered read (latency 1).
module vram_bram (
  input  logic        clk,
  input  logic        we,
  input  logic [1:0]  be,
  input  logic [10:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);
  logic [15:0] mem [2048];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++)
      if (we && be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/vram_arbiter.sv
// Shares one text RAM port between the VGA fetch path (absolute priority),
// a single-outstanding CPU port and a full-screen clear engine.
module vram_arbiter #(
  parameter int          CELLS      = vga_pkg::CELLS,
  parameter logic [15:0] BLANK_CELL = vga_pkg::BLANK_CELL
) (
  input  logic        clk_vga,
  input  logic        rst,
  input  logic        vga_req,
  input  logic [15:0] vga_addr,
  output logic [15:0] vga_data,
  output logic        vga_valid,
  input  logic        cpu_req,
  output logic        cpu_ready,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic [10:0] ram_addr,
  output logic        ram_we,
  output logic [1:0]  ram_be,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);
  vga_pkg::arb_state_e st_q, st_d;
  logic [10:0] cnt_q, cnt_d;
  logic        vga_valid_q, vga_oob_q;
  logic [15:0] rdata_q;
  // captured CPU transaction
  logic        we_q, oob_q;
  logic [10:0] addr_q;
  logic [1:0]  be_q;
  logic [15:0] wdata_q;

  assign cpu_ready  = (st_q == vga_pkg::IDLE) && !clear_start;
  assign cpu_ack    = (st_q == vga_pkg::ACK);
  assign clear_busy = (st_q == vga_pkg::CLEAR);
  assign cpu_rdata  = rdata_q;
  assign vga_valid  = vga_valid_q;
  assign vga_data   = vga_oob_q ? BLANK_CELL : ram_rdata;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      vga_pkg::IDLE: begin
        if (clear_start) begin
          st_d  = vga_pkg::CLEAR;
          cnt_d = '0;
        end else if (cpu_req) begin
          st_d = vga_pkg::ACCESS;
        end
      end
      vga_pkg::ACCESS:  if (!vga_req) st_d = vga_pkg::CAPTURE;
      vga_pkg::CAPTURE: st_d = vga_pkg::ACK;
      vga_pkg::ACK:     st_d = vga_pkg::IDLE;
      vga_pkg::CLEAR: begin
        if (!vga_req) begin
          if (cnt_q == 11'(CELLS - 1)) st_d = vga_pkg::IDLE;
          else                         cnt_d = cnt_q + 11'd1;
        end
      end
      default: st_d = vga_pkg::IDLE;
    endcase
  end

  // RAM port mux: the VGA fetch always wins; writes are squashed during reset
  always_comb begin
    ram_addr  = vga_addr[10:0];
    ram_we    = 1'b0;
    ram_be    = 2'b00;
    ram_wdata = wdata_q;
    if (!vga_req) begin
      case (st_q)
        vga_pkg::ACCESS: begin
          ram_addr = addr_q;
          ram_be   = be_q;
          ram_we   = we_q && !oob_q && (|be_q);
        end
        vga_pkg::CLEAR: begin
          ram_addr  = cnt_q;
          ram_be    = 2'b11;
          ram_wdata = BLANK_CELL;
          ram_we    = 1'b1;
        end
        default: ;
      endcase
    end
    if (rst) ram_we = 1'b0;
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      st_q        <= vga_pkg::IDLE;
      cnt_q       <= '0;
      vga_valid_q <= 1'b0;
      vga_oob_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      vga_valid_q <= vga_req;
      vga_oob_q   <= 32'(vga_addr) >= CELLS;
      if (st_q == vga_pkg::CAPTURE && !we_q)
        rdata_q <= oob_q ? BLANK_CELL : ram_rdata;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (cpu_req && cpu_ready) begin
      we_q    <= cpu_we;
      addr_q  <= cpu_addr;
      be_q    <= cpu_be;
      wdata_q <= cpu_wdata;
      oob_q   <= 32'(cpu_addr) >= CELLS;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter + vram_bram against a cycle-count reference model.
module tb_vram_arbiter;
  localparam int          CELLS = vga_pkg::CELLS;
  localparam logic [15:0] BLANK = vga_pkg::BLANK_CELL;

  logic        clk_vga = 1'b0;
  logic        rst = 1'b1;
  logic        vga_req = 1'b0, vga_valid;
  logic [15:0] vga_addr = '0, vga_data;
  logic        cpu_req = 1'b0, cpu_ready, cpu_we = 1'b0, cpu_ack;
  logic [10:0] cpu_addr = '0;
  logic [1:0]  cpu_be = '0;
  logic [15:0] cpu_wdata = '0, cpu_rdata;
  logic        clear_start = 1'b0, clear_busy;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [1:0]  ram_be;
  logic [15:0] ram_wdata, ram_rdata;

  always #5 clk_vga = ~clk_vga;

  vram_arbiter dut (
    .clk_vga(clk_vga), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
    .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  vram_bram u_ram (
    .clk(clk_vga), .we(ram_we), .be(ram_be), .addr(ram_addr),
    .wdata(ram_wdata), .rdata(ram_rdata)
  );

  // reference model: screen contents plus absolute cycle numbers of events
  logic [15:0] mem_m [2048];
  bit          known [2048];
  int          cyc = 0;
  bit          txn_act = 0, granted = 0, clearing = 0;
  int          g_cyc = 0, ack_cyc = 0, clr_cnt = 0;
  logic        t_we;
  logic [10:0] t_addr;
  logic [1:0]  t_be;
  logic [15:0] t_wd, rd_val;
  bit          rd_known;
  logic [15:0] exp_rdata = '0, exp_vdata = '0;
  bit          exp_rknown = 0, exp_valid = 0, exp_vknown = 0;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // one clock: check outputs of this cycle, advance model, cross the edge
  task automatic step();
    bit          ew, oob, nv, vk;
    logic [15:0] vd;
    logic [10:0] ea;
    #1;
    if (!rst) begin
      chk("vga_valid", 32'(vga_valid), 32'(exp_valid));
      if (exp_valid && exp_vknown) chk("vga_data", 32'(vga_data), 32'(exp_vdata));
      chk("cpu_ack", 32'(cpu_ack), 32'(txn_act && granted && cyc == ack_cyc));
      chk("clear_busy", 32'(clear_busy), 32'(clearing));
      if (exp_rknown) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
      chk("cpu_ready", 32'(cpu_ready), 32'(!txn_act && !clearing && !clear_start));
    end
    ew = 0; ea = '0;
    if (rst) begin
      txn_act = 0; clearing = 0; exp_valid = 0; exp_rdata = '0; exp_rknown = 1;
    end else begin
      nv = vga_req;
      if (32'(vga_addr) >= CELLS) begin vd = BLANK; vk = 1; end
      else begin vd = mem_m[vga_addr[10:0]]; vk = known[vga_addr[10:0]]; end
      if (txn_act) begin
        if (!granted) begin
          if (!vga_req) begin
            granted = 1; g_cyc = cyc; ack_cyc = cyc + 2;
            oob = 32'(t_addr) >= CELLS;
            if (t_we) begin
              if (!oob && t_be != 2'b00) begin
                ew = 1; ea = t_addr;
                if (t_be != 2'b11 && !known[t_addr]) known[t_addr] = 0;
                else known[t_addr] = 1;
                if (t_be[0]) mem_m[t_addr][7:0]  = t_wd[7:0];
                if (t_be[1]) mem_m[t_addr][15:8] = t_wd[15:8];
              end
            end else begin
              rd_val   = oob ? BLANK : mem_m[t_addr];
              rd_known = oob || known[t_addr];
            end
          end
        end else if (cyc == g_cyc + 1) begin
          if (!t_we) begin exp_rdata = rd_val; exp_rknown = rd_known; end
        end else if (cyc == ack_cyc) begin
          txn_act = 0;
        end
      end else if (clearing) begin
        if (!vga_req) begin
          ew = 1; ea = 11'(clr_cnt);
          mem_m[clr_cnt] = BLANK; known[clr_cnt] = 1;
          if (clr_cnt == CELLS - 1) clearing = 0;
          else clr_cnt++;
        end
      end else if (clear_start) begin
        clearing = 1; clr_cnt = 0;
      end else if (cpu_req) begin
        txn_act = 1; granted = 0;
        t_we = cpu_we; t_addr = cpu_addr; t_be = cpu_be; t_wd = cpu_wdata;
      end
      exp_valid = nv; exp_vdata = vd; exp_vknown = vk;
    end
    chk("ram_we", 32'(ram_we), 32'(ew));
    if (ew) chk("ram_addr", 32'(ram_addr), 32'(ea));
    @(posedge clk_vga);
    #1;
    cyc++;
  endtask

  task automatic quiet();
    vga_req = 0; cpu_req = 0; clear_start = 0;
  endtask

  task automatic rand_inputs(input int p_vga, input int p_cpu, input int vga_per);
    int r;
    if (vga_per > 0) vga_req = (cyc % vga_per) == 0;
    else             vga_req = $urandom_range(0, 99) < p_vga;
    r = $urandom_range(0, 9);
    if (r == 0)     vga_addr = 16'($urandom);
    else if (r < 5) vga_addr = 16'($urandom_range(0, 63));
    else            vga_addr = 16'($urandom_range(0, 2047));
    cpu_req   = $urandom_range(0, 99) < p_cpu;
    cpu_we    = 1'($urandom);
    cpu_addr  = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 63)) : 11'($urandom_range(0, 2047));
    cpu_be    = 2'($urandom);
    cpu_wdata = 16'($urandom);
    // clear_start while busy must be ignored
    clear_start = txn_act && ($urandom_range(0, 4) == 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    quiet();
    while ((txn_act || clearing) && n < 3000) begin step(); n++; end
    if (txn_act || clearing) chk("idle_timeout", 32'(1), 32'(0));
  endtask

  task automatic cpu_op(input logic we, input logic [10:0] a, input logic [1:0] be, input logic [15:0] d);
    wait_idle();
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_be = be; cpu_wdata = d;
    step();
    cpu_req = 0;
    repeat (4) step();
  endtask

  task automatic vga_rd(input logic [15:0] a);
    vga_req = 1; vga_addr = a;
    step();
    vga_req = 0;
    step();
  endtask

  initial begin
    int n;
    quiet();
    rst = 1;
    repeat (2) step();
    rst = 0;
    step();

    // directed: plain write then fetch, byte merge, out-of-range read
    cpu_op(1, 11'd5, 2'b11, 16'h1F41);
    vga_rd(16'd5);
    cpu_op(1, 11'd9, 2'b11, 16'h1234);
    cpu_op(1, 11'd9, 2'b01, 16'h00FF);
    cpu_op(0, 11'd9, 2'b11, 16'h0000);
    chk("byte_merge", 32'(cpu_rdata), 32'h12FF);
    cpu_op(0, 11'd2000, 2'b11, 16'h0000);
    chk("oob_read", 32'(cpu_rdata), 32'(BLANK));
    cpu_op(1, 11'd2001, 2'b11, 16'hBEEF);
    cpu_op(1, 11'd6, 2'b00, 16'hDEAD);
    // write deferred by two back-to-back fetches
    wait_idle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 11'd7; cpu_be = 2'b11; cpu_wdata = 16'hA5C3;
    step();
    cpu_req = 0; vga_req = 1; vga_addr = 16'd7;
    repeat (2) step();
    vga_req = 0;
    repeat (4) step();
    vga_rd(16'd7);
    vga_rd(16'hFFFF);

    // random mixed traffic
    repeat (1500) begin rand_inputs(30, 40, 0); step(); end

    // full clear with a fetch every 8th cycle, CPU hammering
    wait_idle();
    clear_start = 1;
    step();
    clear_start = 0;
    n = 0;
    while (clearing && n < 3000) begin
      rand_inputs(0, 100, 8); clear_start = 0; step(); n++;
    end
    if (clearing) chk("clear_timeout", 32'(1), 32'(0));

    repeat (800) begin rand_inputs(20, 50, 0); step(); end

    // clear and CPU request together; reset partway through the clear
    wait_idle();
    clear_start = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 11'd1500; cpu_be = 2'b11; cpu_wdata = 16'h4242;
    step();
    n = 0;
    while (clearing && clr_cnt < 1000 && n < 3000) begin
      rand_inputs(25, 60, 0); clear_start = 0; step(); n++;
    end
    chk("clear_at_1000", 32'(clr_cnt), 32'(1000));
    quiet();
    rst = 1;
    step();
    rst = 0;
    step();

    // sweep every cell through the fetch port
    for (int a = 0; a < 2048; a++) begin
      vga_req = 1; vga_addr = 16'(a); step();
    end
    vga_req = 0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
